// File: rtl/mem_access.sv
// mem_access: data-memory access stage between execute and writeback.
// Runs one load or store on the dmem bus and stalls the core until it completes.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   MemRd, MemWr, MemOp  access request from decode/execute (funct3 size/sign)
//   Result, busB         effective address and store data
//   stall, done, err     core handshake (stall comb, done/err registered)
//   ld_data              extended load data, valid while done=1
//   dmem_*               registered request side, dmem_gnt/rvalid/rdata/err in
//
// Parameter TIMEOUT_CYC (1..255): max cycles spent in REQ+RESP before abort.
// Macro MISALIGN_TRAP_EN: misaligned H/W accesses fail with err and no bus cycle;
// when undefined, the low address bits are forced aligned and never raise err.
module mem_access #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Result,
    input  logic [31:0] busB,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_TO = 8'(TIMEOUT_CYC);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_a;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_ld_data;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_access;
    logic        w_op_bad;
    logic        w_trap;
    logic        w_to_hit;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_ld_ext;

    assign w_access = MemRd | MemWr;

    // Loads accept B/H/W/BU/HU; stores have no unsigned forms.
    assign w_op_bad = (MemRd & MemWr)
                    | (MemOp[1:0] == 2'b11)
                    | (MemOp[2] & (MemOp[1] | MemWr));

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((MemOp[1:0] == 2'b01) & Result[0])
                      | ((MemOp[1:0] == 2'b10) & (Result[1:0] != 2'b00));
    assign w_trap = w_op_bad | w_misalign;
`else
    assign w_trap = w_op_bad;
`endif

    // Strobes derive only from the lane bits that matter for the size,
    // which is what forces misaligned H/W accesses back into alignment.
    always_comb begin
        w_wdata = 32'h0;
        w_wstrb = 4'h0;
        if (MemWr) begin
            case (MemOp[1:0])
                2'b00: begin
                    w_wdata = {4{busB[7:0]}};
                    w_wstrb = 4'b0001 << Result[1:0];
                end
                2'b01: begin
                    w_wdata = {2{busB[15:0]}};
                    w_wstrb = 4'b0011 << {Result[1], 1'b0};
                end
                default: begin
                    w_wdata = busB;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    function automatic logic [31:0] f_extract(
        input logic [31:0] d,
        input logic [2:0]  op,
        input logic [1:0]  a
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b100:  f_extract = {24'h0, b};
            3'b101:  f_extract = {16'h0, h};
            default: f_extract = d;
        endcase
    endfunction

    assign w_ld_ext = f_extract(dmem_rdata, r_op, r_a);
    assign w_to_hit = (r_cnt + 8'd1) == LP_TO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'h0;
            r_op      <= 3'h0;
            r_a       <= 2'h0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ld_data <= 32'h0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_cnt <= 8'h0;
                        if (w_trap) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= MemWr;
                            r_addr  <= {Result[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_wstrb <= w_wstrb;
                            r_op    <= MemOp;
                            r_a     <= Result[1:0];
                        end
                    end
                end
                S_REQ: begin
                    // Timeout wins over a late grant so the count never wraps.
                    if (w_to_hit) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (dmem_gnt) begin
                            r_req   <= 1'b0;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= dmem_err;
                        r_ld_data <= r_we ? 32'h0 : w_ld_ext;
                    end else if (w_to_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // Inputs here belong to the finished instruction; drop them.
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                    r_ld_data <= 32'h0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall      = ((r_state == S_IDLE) & w_access)
                      | (r_state == S_REQ)
                      | (r_state == S_RESP);
    assign done       = r_done;
    assign err        = r_err;
    assign ld_data    = r_ld_data;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_wstrb = r_wstrb;

endmodule
